// File: rtl/serial_io_cs_controller.sv
// serial_io_cs_controller
//   Decodes CPU IO-window accesses onto NUM_PORTS UART chip selects. Each port
//   owns one 16-byte block starting at block BASE_BLOCK. A valid access holds
//   the port enable for WAIT_STATES+1 cycles and strobes Ack_H on the last one.
//   An in-range access on the odd byte lane is rejected with LaneErr_H/Ack_H
//   and counted in a saturating error counter. All outputs are registered.
//
// Ports
//   Clock         in   rising-edge system clock
//   Reset         in   synchronous active-high reset
//   Address[15:0] in   CPU address within the IO window
//   IOSelect_H    in   IO window select, held for the whole access
//   ByteSelect_L  in   low = even byte lane (D15-D8)
//   Port_Enable   out  one-hot registered chip enables
//   Ack_H         out  one-cycle access-complete strobe
//   LaneErr_H     out  one-cycle wrong-lane strobe
//   Busy_H        out  high whenever the FSM is not IDLE
//   Error_Count   out  saturating count of lane errors
module serial_io_cs_controller #(
  parameter int          NUM_PORTS   = 3,
  parameter logic [11:0] BASE_BLOCK  = 12'h100,
  parameter int          WAIT_STATES = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [15:0]          Address,
  input  logic                 IOSelect_H,
  input  logic                 ByteSelect_L,
  output logic [NUM_PORTS-1:0] Port_Enable,
  output logic                 Ack_H,
  output logic                 LaneErr_H,
  output logic                 Busy_H,
  output logic [7:0]           Error_Count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACTIVE  = 2'd1;
  localparam logic [1:0] LERR    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

  // 17-bit bounds so the upper limit cannot wrap past 16'hFFFF.
  localparam logic [16:0] ADDR_LO = {1'b0, BASE_BLOCK, 4'h0};
  localparam logic [16:0] ADDR_HI = ADDR_LO + 17'(NUM_PORTS * 16);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0]  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  port, port_nxt;
  logic        hit;
  logic [3:0]  port_idx;

  // Block offset fits in 4 bits, so only the low block nibble matters.
  assign hit      = ({1'b0, Address} >= ADDR_LO) && ({1'b0, Address} < ADDR_HI);
  assign port_idx = Address[7:4] - BASE_BLOCK[3:0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    port_nxt  = port;
    case (state)
      IDLE: begin
        if (IOSelect_H && hit) begin
          if (!ByteSelect_L) begin
            port_nxt  = port_idx;
            cnt_nxt   = 4'(WAIT_STATES);
            state_nxt = ACTIVE;
          end else begin
            state_nxt = LERR;
          end
        end
      end
      ACTIVE: begin
        if (!IOSelect_H)      state_nxt = IDLE;
        else if (cnt == 4'd0) state_nxt = RELEASE;
        else                  cnt_nxt   = cnt - 4'd1;
      end
      LERR:    state_nxt = RELEASE;
      default: if (!IOSelect_H) state_nxt = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so each output
  // lines up with the cycle the FSM actually spends in that state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      Port_Enable <= '0;
      Ack_H       <= 1'b0;
      LaneErr_H   <= 1'b0;
      Busy_H      <= 1'b0;
      Error_Count <= 8'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      Port_Enable <= (state_nxt == ACTIVE) ? (ONE << port_nxt) : '0;
      Ack_H       <= ((state_nxt == ACTIVE) && (cnt_nxt == 4'd0)) || (state_nxt == LERR);
      LaneErr_H   <= (state_nxt == LERR);
      Busy_H      <= (state_nxt != IDLE);
      if (state_nxt == LERR) Error_Count <= sat_inc(Error_Count);
    end
  end

  // Latched port index is pure data; it is only observed while ACTIVE.
  always_ff @(posedge Clock) begin
    port <= port_nxt;
  end

endmodule

// File: doc/serial_io_cs_controller.md
SERIAL_IO_CS_CONTROLLER -- requirements
Module: serial_io_cs_controller

Interface
REQ-001 Parameter NUM_PORTS, default 3, number of UART chip-select channels, legal range 1..16.
REQ-002 Parameter BASE_BLOCK, default 12'h100, 16-byte block index (Address[15:4]) of port 0; port i occupies block BASE_BLOCK+i.
REQ-003 Parameter WAIT_STATES, default 2, extra enable cycles per access, legal range 0..15.
REQ-004 Clock  in  1  rising-edge system clock.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Address  in  16  CPU address bits A15:A0 within the IO window.
REQ-007 IOSelect_H  in  1  high while the CPU addresses the IO window; held high for the whole access.
REQ-008 ByteSelect_L  in  1  low selects the even byte lane, D15-D8.
REQ-009 Port_Enable  out  NUM_PORTS  one-hot registered chip enable, bit i for port i.
REQ-010 Ack_H  out  1  one-cycle access-complete strobe.
REQ-011 LaneErr_H  out  1  one-cycle strobe: in-range access on the wrong byte lane.
REQ-012 Busy_H  out  1  high whenever the FSM is not IDLE.
REQ-013 Error_Count  out  8  saturating count of lane errors.

Function
REQ-014 The block SHALL treat an access as a hit when Address[15:4] is in BASE_BLOCK..BASE_BLOCK+NUM_PORTS-1, using unsigned 12-bit compare with no wrap past 12'hFFF; the port index is Address[15:4]-BASE_BLOCK.
REQ-015 The block SHALL ignore out-of-range addresses: no enable, no Ack_H, no LaneErr_H, FSM stays IDLE.
REQ-016 The FSM SHALL have the states IDLE, ACTIVE, LERR and RELEASE.
REQ-017 IDLE: on a cycle with IOSelect_H=1, a hit and ByteSelect_L=0, latch the port index, load the wait counter with WAIT_STATES, and go to ACTIVE.
REQ-018 IDLE: on a cycle with IOSelect_H=1, a hit and ByteSelect_L=1, go to LERR.
REQ-019 ACTIVE: Port_Enable[latched index]=1 and all other bits 0; if the counter is 0, assert Ack_H and go to RELEASE, otherwise decrement the counter.
REQ-020 Enable timing SHALL be as follows: enable rises one cycle after the start sample, stays high exactly WAIT_STATES+1 cycles, and Ack_H coincides with its last cycle.
REQ-021 LERR: assert LaneErr_H and Ack_H for one cycle, increment Error_Count (saturating at 8'hFF), then go to RELEASE.
REQ-022 RELEASE: all enables 0; go to IDLE on the first cycle IOSelect_H=0, otherwise remain.
REQ-023 Abort: if IOSelect_H=0 in ACTIVE, the FSM SHALL go to IDLE next cycle with enables 0 that cycle and SHALL NOT assert Ack_H; the abort cycle itself still drives the enable.
REQ-024 Address and ByteSelect_L changes after the start sample SHALL NOT affect the latched port or the state.
REQ-025 Back-to-back accesses SHALL require at least one IOSelect_H-low cycle; one-hot enable is guaranteed at all times.
REQ-026 Busy_H SHALL be 1 in ACTIVE, LERR and RELEASE, and 0 in IDLE.
REQ-027 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-028 With Reset=1 at a clock edge, the block SHALL enter IDLE with Port_Enable=0, Ack_H=0, LaneErr_H=0, Busy_H=0, Error_Count=0 and the counter at 0, regardless of current state.
REQ-029 Reset SHALL take priority over every other input, including mid-ACTIVE; the next access after reset release SHALL decode normally.

Verification
REQ-030 Defaults: Address=16'h1010, IOSelect_H=1, ByteSelect_L=0 held -> Port_Enable=3'b010 for 3 cycles starting 1 cycle after the sample, Ack_H on the 3rd cycle, then 0 until IOSelect_H drops.
REQ-031 Address=16'h1030 (out of range, NUM_PORTS=3) with IOSelect_H=1 -> Port_Enable=0, Ack_H=0, Busy_H=0 throughout.
REQ-032 Address=16'h1000, ByteSelect_L=1 -> LaneErr_H=Ack_H=1 for one cycle, Error_Count 0->1; 256 such accesses -> Error_Count holds at 8'hFF.
REQ-033 IOSelect_H dropped on the 2nd ACTIVE cycle -> enable low the next cycle, no Ack_H, Busy_H=0; next access to 16'h1020 -> Port_Enable=3'b100 normally.
REQ-034 Reset asserted on the 2nd ACTIVE cycle -> next edge all outputs 0 and Error_Count=0.
REQ-035 WAIT_STATES=0, NUM_PORTS=16, BASE_BLOCK=12'hFF8: access to 16'hFFF4 -> Port_Enable bit 7 for 1 cycle with Ack_H; the compare SHALL NOT wrap, so blocks 12'h000-12'h007 are ignored.
